// File: rtl/expmod31_ctrl.sv
// expmod31_ctrl: X^E mod 31 by left-to-right square-and-multiply on one shared multmod31.
// multmod31 is a combinational canonical modular product; inputs may be 31 (congruent to 0).
module multmod31 (
    input  logic [4:0] a,
    input  logic [4:0] b,
    output logic [4:0] p
);
    logic [9:0] full;
    logic [5:0] fold1;
    logic [4:0] fold2;
    // 32 == 1 (mod 31), so folding the 5-bit digits preserves the residue
    always_comb begin
        full  = a * b;
        fold1 = {1'b0, full[9:5]} + {1'b0, full[4:0]};
        fold2 = fold1[4:0] + {4'd0, fold1[5]};
        p     = (fold2 == 5'd31) ? 5'd0 : fold2;
    end
endmodule

module expmod31_ctrl #(
    parameter int EW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [4:0]    base,
    input  logic [EW-1:0] exp,
    output logic          busy,
    output logic          done,
    output logic [4:0]    result
);
    localparam int IW = (EW > 1) ? $clog2(EW) : 1;
    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;
    state_t        state_q, state_d;
    logic [4:0]    acc_q, acc_d, base_q, base_d, result_q, result_d, prod;
    logic [EW-1:0] exp_q, exp_d;
    logic [IW-1:0] idx_q, idx_d;

    multmod31 u_mult (.a(acc_q), .b(state_q == MUL ? base_q : acc_q), .p(prod));

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        base_d   = base_q;
        exp_d    = exp_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (start) begin
                base_d  = base;
                exp_d   = exp;
                acc_d   = 5'd1;
                idx_d   = IW'(EW - 1);
                state_d = SQR;
            end
            SQR: begin
                acc_d = prod;
                if (exp_q[idx_q]) state_d = MUL;
                else if (idx_q == '0) begin
                    state_d  = DONE;
                    result_d = prod;
                end else idx_d = idx_q - 1'b1;
            end
            MUL: begin
                acc_d = prod;
                if (idx_q == '0) begin
                    state_d  = DONE;
                    result_d = prod;
                end else begin
                    idx_d   = idx_q - 1'b1;
                    state_d = SQR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= 5'd1;
            idx_q    <= IW'(EW - 1);
            base_q   <= '0;
            exp_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == SQR) || (state_q == MUL);
    assign done   = (state_q == DONE);
    assign result = result_q;
endmodule

// File: tb/tb_expmod31_ctrl.sv
// tb_expmod31_ctrl: directed table, corner sequences and random back-to-back runs against a pow-mod-31 model.
module tb_expmod31_ctrl;
    localparam int EW = 5;
    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [4:0]    base = '0;
    logic [EW-1:0] exp = '0;
    logic          busy, done;
    logic [4:0]    result;
    int n_cmp = 0, n_bad = 0;

    expmod31_ctrl #(.EW(EW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .exp(exp),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        int b;
        int e;
        int res;
        int lat;
    } vec_t;
    vec_t vecs[8];

    function automatic int pow31(int b, int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % 31;
        return r;
    endfunction

    function automatic int n_of(int e);
        return EW + $countones(e[EW-1:0]);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // returns at the negedge where done is seen (or after the bound expires)
    task automatic wait_done(output int lat, output int bcnt);
        lat = 0;
        bcnt = 0;
        while (!done && lat < 200) begin
            bcnt += busy;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run(input int b, input int e, output int res, output int lat, output int bcnt);
        @(negedge clk);
        base = 5'(b);
        exp = EW'(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcnt);
        res = int'(result);
    endtask

    initial begin
        int res, lat, bcnt, cb, ce, nb, ne;
        vecs[0] = '{2, 5, 1, 7};
        vecs[1] = '{3, 31, 3, 10};
        vecs[2] = '{5, 2, 25, 6};
        vecs[3] = '{3, 0, 1, 5};
        vecs[4] = '{31, 4, 0, 6};
        vecs[5] = '{0, 3, 0, 7};
        vecs[6] = '{31, 0, 1, 5};
        vecs[7] = '{0, 0, 1, 5};

        #3;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run(vecs[i].b, vecs[i].e, res, lat, bcnt);
            chk($sformatf("vec%0d_result", i), res, vecs[i].res);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_busy", i), bcnt, vecs[i].lat);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), done, 0);
            chk($sformatf("vec%0d_result_hold", i), result, vecs[i].res);
        end

        // start and operand changes while busy are ignored and not queued
        @(negedge clk);
        base = 5'd3;
        exp = EW'(31);
        start = 1'b1;
        @(negedge clk);
        base = 5'd5;
        exp = EW'(2);
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcnt);
        chk("busy_ignore_result", result, 3);
        chk("busy_ignore_latency", lat, 8);
        repeat (3) @(negedge clk);
        chk("no_queued_start", busy, 0);

        // asynchronous reset mid-computation
        run(5, 2, res, lat, bcnt);
        chk("pre_reset_result", res, 25);
        @(negedge clk);
        base = 5'd3;
        exp = EW'(31);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_result", result, 0);
        repeat (2) @(negedge clk);
        chk("rst_no_done", done, 0);
        rst_n = 1'b1;
        run(2, 5, res, lat, bcnt);
        chk("post_reset_result", res, 1);
        chk("post_reset_latency", lat, 7);

        // random back-to-back with start held high; next operands driven right after each acceptance
        @(negedge clk);
        cb = $urandom_range(31);
        ce = $urandom_range(31);
        base = 5'(cb);
        exp = EW'(ce);
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 60; i++) begin
            nb = $urandom_range(31);
            ne = $urandom_range(31);
            base = 5'(nb);
            exp = EW'(ne);
            wait_done(lat, bcnt);
            chk($sformatf("rnd%0d_result b=%0d e=%0d", i, cb, ce), result, pow31(cb, ce));
            chk($sformatf("rnd%0d_latency", i), lat, n_of(ce));
            @(negedge clk);
            chk($sformatf("rnd%0d_done_pulse", i), done, 0);
            @(negedge clk);
            chk($sformatf("rnd%0d_restart", i), busy, 1);
            cb = nb;
            ce = ne;
        end
        start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
